nand_unit_arbiter: RTL and testbench

//  Shares one registered WIDTH-bit bitwise logic unit (NAND by default) among NREQ requesters.

---
 rtl/nand_unit_arbiter.sv | 157 +++++++++++++++
 tb/tb_nand_unit_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nand_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit (NAND) among NREQ requesters.
// Define NAND_ARB_OPSEL_EN to select AND/OR/XOR/NAND per request via op_in.
module nand_unit_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_in,
  input  logic [NREQ*WIDTH-1:0]   b_in,
  input  logic [NREQ*2-1:0]       op_in,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        res_out,
  output logic                    res_valid,
  output logic [IDW-1:0]          res_id,
  output logic                    busy
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     w_q, w_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               res_valid_q, res_valid_d;
  logic [IDW-1:0]     res_id_q, res_id_d;
  logic               busy_q, busy_d;
  logic               found;
  logic [IDW-1:0]     win;
  logic [WIDTH-1:0]   f_res;

  // Rotating priority search starting at ptr
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int k = 0; k < int'(NREQ); k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % int'(NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

`ifdef NAND_ARB_OPSEL_EN
  logic [1:0] op_q, op_d;

  always_comb begin
    case (op_q)
      2'b00:   f_res = ~(a_q & b_q);
      2'b01:   f_res = a_q & b_q;
      2'b10:   f_res = a_q | b_q;
      default: f_res = a_q ^ b_q;
    endcase
  end

  always_comb begin
    op_d = op_q;
    if (state_q == S_IDLE && found) op_d = op_in[int'(win)*2 +: 2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_q <= 2'b00;
    else     op_q <= op_d;
  end
`else
  logic unused_op_in;
  assign unused_op_in = ^op_in;
  assign f_res        = ~(a_q & b_q);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_EVAL;
      S_EVAL:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; gnt/res_valid default low so each is a single-cycle pulse
  always_comb begin
    ptr_d       = ptr_q;
    w_d         = w_q;
    a_d         = a_q;
    b_d         = b_q;
    gnt_d       = '0;
    res_d       = res_q;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    busy_d      = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (found) begin
          w_d   = win;
          a_d   = a_in[int'(win)*WIDTH +: WIDTH];
          b_d   = b_in[int'(win)*WIDTH +: WIDTH];
          gnt_d = NREQ'(1) << win;
        end
      end
      S_EVAL: begin
        res_d       = f_res;
        res_id_d    = w_q;
        res_valid_d = 1'b1;
      end
      S_DONE: begin
        ptr_d = (w_q == IDW'(NREQ - 1)) ? '0 : w_q + IDW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      w_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      gnt_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      w_q         <= w_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gnt_q       <= gnt_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign res_out   = res_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nand_unit_arbiter.sv
// Scoreboard bench for nand_unit_arbiter: stimulus pushes expected grants/results, a monitor pops them.
module tb_nand_unit_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ*2-1:0]     op_in;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      res_out;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic                  busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [NREQ-1:0]      exp_gnt[$];
  logic [IDW+WIDTH-1:0] exp_res[$];

  nand_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .gnt(gnt), .res_out(res_out), .res_valid(res_valid), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name, input logic [31:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0h expected nothing (t=%0t)", name, act, $time);
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or a result
  always @(negedge clk) begin
    logic [NREQ-1:0]      g;
    logic [IDW+WIDTH-1:0] r;
    check("gnt_valid_exclusive", 32'(gnt != '0 && res_valid), 32'd0);
    if (gnt != '0) begin
      if (exp_gnt.size() == 0) fail_evt("unexpected_gnt", 32'(gnt));
      else begin
        g = exp_gnt.pop_front();
        check("gnt", 32'(gnt), 32'(g));
      end
    end
    if (res_valid) begin
      if (exp_res.size() == 0) fail_evt("unexpected_res_valid", 32'(res_out));
      else begin
        r = exp_res.pop_front();
        check("res_out", 32'(res_out), 32'(r[WIDTH-1:0]));
        check("res_id", 32'(res_id), 32'(r[IDW+WIDTH-1:WIDTH]));
      end
    end
  end

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    a_in[i*WIDTH +: WIDTH] = a;
    b_in[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic push(input logic [NREQ-1:0] g, input logic [IDW-1:0] id, input logic [7:0] r);
    exp_gnt.push_back(g);
    exp_res.push_back({id, r});
  endtask

  // Requesters drop req after seeing gnt; returns when everything expected has been observed
  task automatic drain(input bit gap_chk);
    int last = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (gnt != '0) begin
        if (gap_chk && last >= 0) check("grant_gap", 32'(cyc - last), 32'd3);
        last = cyc;
        req = req & ~gnt;
      end
      if (req == '0 && !busy && exp_gnt.size() == 0 && exp_res.size() == 0) return;
    end
    fail_evt("drain_timeout", 32'(req));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},       32'(gnt),       32'd0);
    check({tag, "_res_out"},   32'(res_out),   32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_id"},    32'(res_id),    32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] op_exp [4];
`ifdef NAND_ARB_OPSEL_EN
    op_exp = '{8'hF5, 8'h0A, 8'hAF, 8'hA5};
`else
    op_exp = '{8'hF5, 8'hF5, 8'hF5, 8'hF5};
`endif
    rst = 1'b1; req = '0; a_in = '0; b_in = '0; op_in = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Single op
    set_ops(0, 8'hF0, 8'h3C);
    req = 4'b0001;
    push(4'b0001, 2'd0, 8'hCF);
    drain(1'b0);

    // Reset during EVAL discards the operation
    set_ops(1, 8'h55, 8'h55);
    req = 4'b0010;
    exp_gnt.push_back(4'b0010);
    @(negedge clk);
    #1 rst = 1'b1; req = '0;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Contention from ptr=0
    set_ops(0, 8'hF0, 8'hFF);
    set_ops(1, 8'h0F, 8'h0F);
    set_ops(2, 8'hFF, 8'h55);
    set_ops(3, 8'h00, 8'hAA);
    req = 4'b1111;
    push(4'b0001, 2'd0, 8'h0F);
    push(4'b0010, 2'd1, 8'hF0);
    push(4'b0100, 2'd2, 8'hAA);
    push(4'b1000, 2'd3, 8'hFF);
    drain(1'b1);

    // Move ptr to 3, then wrap 3 -> 0, leaving ptr at 1
    set_ops(2, 8'hFF, 8'hFF);
    req = 4'b0100;
    push(4'b0100, 2'd2, 8'h00);
    drain(1'b0);
    set_ops(3, 8'h81, 8'hFF);
    set_ops(0, 8'h3C, 8'hC3);
    req = 4'b1001;
    push(4'b1000, 2'd3, 8'h7E);
    push(4'b0001, 2'd0, 8'hFF);
    drain(1'b0);
    set_ops(1, 8'hFF, 8'h01);
    req = 4'b0011;
    push(4'b0010, 2'd1, 8'hFE);
    push(4'b0001, 2'd0, 8'hFF);
    drain(1'b0);

    // Operand change during EVAL must not affect the result
    set_ops(0, 8'hF0, 8'h3C);
    req = 4'b0001;
    push(4'b0001, 2'd0, 8'hCF);
    @(negedge clk);
    a_in[7:0] = 8'h00;
    req = '0;
    drain(1'b0);

    // Op select sweep
    set_ops(0, 8'hAA, 8'h0F);
    for (int op = 0; op < 4; op++) begin
      op_in[1:0] = 2'(op);
      req = 4'b0001;
      push(4'b0001, 2'd0, op_exp[op]);
      drain(1'b0);
    end

    repeat (3) @(negedge clk);
    check("queues_empty", 32'(exp_gnt.size() + exp_res.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
